fifo_pack_2x32: RTL

Receive-side counterpart of the 32-to-2 shift-out path: accepts a stream of 2-bit symbols, packs 16 consecutive symbols LSB-first into one 32-bit word, and buffers the words in an internal synchronous FIFO for the host read channel (32-bit read stream). A flush input closes a partial word with zero padding so the host can drain a stream whose length is not a multiple of 16 symbols.

---
 rtl/fifo_pack_2x32_pkg.sv | 33 +++
 rtl/sync_fifo_32.sv | 83 ++++++++
 rtl/fifo_pack_2x32.sv | 97 +++++++++
 3 files changed

// File: rtl/fifo_pack_2x32_pkg.sv
//------------------------------------------------------------------------------
// fifo_pack_2x32_pkg
// Shared widths, defaults and packer state encoding for fifo_pack_2x32.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package fifo_pack_2x32_pkg;

  localparam int SYM_W         = 2;
  localparam int WORD_W        = 32;
  localparam int SYMS_PER_WORD = 16;
  localparam int CNT_W         = 4;
  localparam int DEPTH_DEFAULT = 512;
  localparam int AW_DEFAULT    = 9;

  typedef enum logic {
    PK_FILL = 1'b0,
    PK_PEND = 1'b1
  } pk_state_t;

  // Symbol k occupies bits [2k+1:2k] of the word.
  function automatic logic [WORD_W-1:0] place_sym(input logic [SYM_W-1:0] s,
                                                  input logic [CNT_W-1:0] k);
    logic [WORD_W-1:0] w;
    w = '0;
    w[SYM_W-1:0] = s;
    return w << {k, 1'b0};
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo_32.sv
//------------------------------------------------------------------------------
// sync_fifo_32
// Single-clock 32-bit FIFO with registered read data and registered flags.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sync_fifo_32 #(
  parameter int DEPTH = 512,
  parameter int AW    = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [31:0]   wr_data,
  input  logic          rd_en,
  output logic [31:0]   rd_data,
  output logic          rd_valid,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic [31:0]   rd_data_q, rd_data_d;
  logic          rd_valid_q, rd_valid_d;
  logic          pop, push;

  always_comb begin
    pop        = rd_en && !empty_q;
    // A pop frees the slot a same-edge push lands in, so full does not block it.
    push       = wr_en && (!full_q || pop);
    wr_ptr_d   = wr_ptr_q + AW'(push);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    level_d    = level_q + (AW+1)'(push) - (AW+1)'(pop);
    full_d     = (level_d == FULL_LVL);
    empty_d    = (level_d == '0);
    rd_valid_d = pop;
    rd_data_d  = pop ? mem_q[rd_ptr_q] : rd_data_q;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign full     = full_q;
  assign empty    = empty_q;
  assign level    = level_q;

endmodule

`default_nettype wire

// File: rtl/fifo_pack_2x32.sv
//------------------------------------------------------------------------------
// fifo_pack_2x32
// Packs 2-bit symbols LSB-first into 32-bit words and buffers them in a FIFO.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fifo_pack_2x32
  import fifo_pack_2x32_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int AW    = AW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    sym_in,
  input  logic          sym_valid,
  output logic          sym_ready,
  input  logic          flush,
  output logic [31:0]   data_out,
  output logic          data_out_valid,
  input  logic          data_out_rden,
  output logic          fifo_full,
  output logic          fifo_empty,
  output logic [AW:0]   fill_level,
  output logic [3:0]    sym_count
);

  pk_state_t         state_q, state_d;
  logic [WORD_W-1:0] acc_q, acc_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] acc_sym;
  logic              accept, last_sym, close_word, fifo_wr;

  assign sym_ready = !((state_q == PK_PEND) && fifo_full);

  always_comb begin
    accept     = sym_valid && sym_ready;
    last_sym   = accept && (cnt_q == CNT_W'(SYMS_PER_WORD - 1));
    acc_sym    = acc_q | (accept ? place_sym(sym_in, cnt_q) : '0);
    // Flush counts a symbol accepted in the same cycle toward the partial word.
    close_word = last_sym || (flush && sym_ready && (accept || (cnt_q != '0)));
    fifo_wr    = (state_q == PK_PEND) &&
                 (!fifo_full || (data_out_rden && !fifo_empty));

    state_d = state_q;
    word_d  = word_q;
    acc_d   = acc_sym;
    cnt_d   = cnt_q + CNT_W'(accept);

    if (fifo_wr) begin
      state_d = PK_FILL;
    end
    if (close_word) begin
      word_d  = acc_sym;
      state_d = PK_PEND;
      acc_d   = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PK_FILL;
      acc_q   <= '0;
      word_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sym_count = cnt_q;

  sync_fifo_32 #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (fifo_wr),
    .wr_data  (word_q),
    .rd_en    (data_out_rden),
    .rd_data  (data_out),
    .rd_valid (data_out_valid),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (fill_level)
  );

endmodule

`default_nettype wire
